// File: rtl/edp_vec_pkg.sv
// Shared types and constants for the EDP vector player.
// The MISR taps are used only when EDP_VEC_SIGNATURE_EN is defined.
package edp_vec_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } vec_state_t;

    // Feedback taps, given as offsets from the MSB: sig[W-1] ^ sig[W-3].
    localparam int MISR_TAP_A = 1;
    localparam int MISR_TAP_B = 3;

    // One vector slot at the default widths. The RAM word packs the same
    // fields in the same order for any WIDTH/CTL_W.
    typedef struct packed {
        logic [35:0] data;
        logic [31:0] ctl;
        logic [35:0] exp;
        logic [35:0] mask;
    } edp_vec_t;

endpackage

// File: rtl/edp_vec_ram.sv
// Vector slot storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module edp_vec_ram #(
    parameter int WIDTH = 36,
    parameter int CTL_W = 32,
    parameter int DEPTH = 16
) (
    input  logic                         eboxClk,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     waddr,
    input  logic [3*WIDTH+CTL_W-1:0]     wdata,
    input  logic [$clog2(DEPTH)-1:0]     raddr,
    output logic [3*WIDTH+CTL_W-1:0]     rdata
);

    logic [3*WIDTH+CTL_W-1:0] mem [DEPTH];

    always_ff @(posedge eboxClk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/edp_vec_player.sv
// EDP stimulus/response player: replays stored vectors, waits LAT cycles, checks masked result.
// Optional MISR signature output enabled by defining EDP_VEC_SIGNATURE_EN.
//
// state | meaning
// IDLE  | waiting for start; slot writes accepted
// APPLY | drive slot idx onto stimData/stimCtl, load wait down-counter
// WAIT  | hold stimulus while the EDP settles (LAT-1 cycles)
// CHECK | sample obsData, compare under mask, pick next slot or finish
// DONE  | one-cycle done pulse, back to IDLE
module edp_vec_player
    import edp_vec_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int CTL_W = 32,
    parameter int DEPTH = 16,
    parameter int LAT   = 1
) (
    input  logic                       eboxClk,
    input  logic                       eboxReset_n,
    input  logic                       wrEn,
    input  logic [$clog2(DEPTH)-1:0]   wrAddr,
    input  logic [WIDTH-1:0]           wrData,
    input  logic [CTL_W-1:0]           wrCtl,
    input  logic [WIDTH-1:0]           wrExp,
    input  logic [WIDTH-1:0]           wrMask,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       stopOnFail,
    output logic [WIDTH-1:0]           stimData,
    output logic [CTL_W-1:0]           stimCtl,
    output logic                       stimValid,
    input  logic [WIDTH-1:0]           obsData,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(DEPTH):0]     failCount,
    output logic [$clog2(DEPTH)-1:0]   failIndex,
    output logic [WIDTH-1:0]           failObs
`ifdef EDP_VEC_SIGNATURE_EN
    ,
    output logic [WIDTH-1:0]           sig
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = 3*WIDTH + CTL_W;
    localparam logic [CW-1:0] FC_MAX    = '1;
    localparam logic [2:0]    WAIT_INIT = 3'(LAT - 1);

    vec_state_t        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [2:0]        wait_q, wait_d;
    logic [CW-1:0]     cnt_q;
    logic              sof_q;

    logic [VW-1:0]     vec_word;
    logic [WIDTH-1:0]  vec_data, vec_exp, vec_mask;
    logic [CTL_W-1:0]  vec_ctl;

    logic              run_state;
    logic              start_run, start_zero;
    logic              mismatch, fail_inc, is_last, run_end;
    logic [CW-1:0]     fail_cnt_d;

    // Writes are blocked while running, so the active slot cannot change under the read port.
    edp_vec_ram #(
        .WIDTH (WIDTH),
        .CTL_W (CTL_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .eboxClk (eboxClk),
        .we      (wrEn && !run_state),
        .waddr   (wrAddr),
        .wdata   ({wrData, wrCtl, wrExp, wrMask}),
        .raddr   (idx_q),
        .rdata   (vec_word)
    );

    assign vec_mask = vec_word[WIDTH-1:0];
    assign vec_exp  = vec_word[2*WIDTH-1:WIDTH];
    assign vec_ctl  = vec_word[2*WIDTH+CTL_W-1:2*WIDTH];
    assign vec_data = vec_word[VW-1:2*WIDTH+CTL_W];

    assign run_state = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
    assign busy      = run_state;
    assign stimValid = run_state;
    assign stimData  = run_state ? vec_data : '0;
    assign stimCtl   = run_state ? vec_ctl  : '0;

    assign start_run  = (state_q == IDLE) && start && (count != '0);
    assign start_zero = (state_q == IDLE) && start && (count == '0);

    assign mismatch   = |((obsData ^ vec_exp) & vec_mask);
    assign fail_inc   = (state_q == CHECK) && mismatch;
    assign fail_cnt_d = (fail_inc && (failCount != FC_MAX)) ? failCount + CW'(1) : failCount;
    assign is_last    = ({1'b0, idx_q} == (cnt_q - CW'(1)));
    assign run_end    = run_state && (state_d == DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (start_run) begin
                    state_d = APPLY;
                    idx_d   = '0;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_d = DONE;
                end else begin
                    wait_d  = WAIT_INIT;
                    state_d = (LAT == 1) ? CHECK : WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = DONE;
                end else begin
                    wait_d = wait_q - 3'd1;
                    if (wait_d == 3'd0) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (abort || (mismatch && sof_q) || is_last) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = APPLY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            cnt_q     <= '0;
            sof_q     <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            failCount <= '0;
            failIndex <= '0;
            failObs   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            done    <= (state_d == DONE) || start_zero;
            if (start_run || start_zero) begin
                cnt_q     <= count;
                sof_q     <= stopOnFail;
                pass      <= start_zero;
                failCount <= '0;
                failIndex <= '0;
                failObs   <= '0;
            end else begin
                if (fail_inc) begin
                    failCount <= fail_cnt_d;
                    if (failCount == '0) begin
                        failIndex <= idx_q;
                        failObs   <= obsData;
                    end
                end
                // Abort overrides pass even if the final compare was clean.
                if (run_end) begin
                    pass <= !abort && (fail_cnt_d == '0);
                end
            end
        end
    end

`ifdef EDP_VEC_SIGNATURE_EN
    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            sig <= '0;
        end else if (start_run || start_zero) begin
            sig <= '0;
        end else if (state_q == CHECK) begin
            sig <= {sig[WIDTH-2:0], sig[WIDTH-MISR_TAP_A] ^ sig[WIDTH-MISR_TAP_B]} ^ obsData;
        end
    end
`endif

endmodule

// File: tb/tb_edp_vec_player.sv
// Self-checking bench for edp_vec_player: vector table, corner sequences, random runs vs. model.
module tb_edp_vec_player;

    logic        eboxClk = 1'b0;
    always #5 eboxClk = ~eboxClk;

    logic        eboxReset_n;
    logic        wrEn;
    logic [3:0]  wrAddr;
    logic [35:0] wrData, wrExp, wrMask;
    logic [31:0] wrCtl;
    logic [4:0]  count;
    logic        start1, start3, abort1, abort3, stopOnFail;

    logic [35:0] sd1, sd3, fo1, fo3, obs1, obs3;
    logic [31:0] sc1, sc3;
    logic        sv1, sv3, busy1, busy3, done1, done3, pass1, pass3;
    logic [4:0]  fc1, fc3;
    logic [3:0]  fi1, fi3;
`ifdef EDP_VEC_SIGNATURE_EN
    logic [35:0] sig1, sig3;
`endif

    // EDP stand-in: result is the data word with the control word XORed into its low bits.
    assign obs1 = sd1 ^ {4'b0, sc1};
    assign obs3 = sd3 ^ {4'b0, sc3};

    edp_vec_player #(.WIDTH(36), .CTL_W(32), .DEPTH(16), .LAT(1)) dut1 (
        .eboxClk(eboxClk), .eboxReset_n(eboxReset_n), .wrEn(wrEn), .wrAddr(wrAddr),
        .wrData(wrData), .wrCtl(wrCtl), .wrExp(wrExp), .wrMask(wrMask), .count(count),
        .start(start1), .abort(abort1), .stopOnFail(stopOnFail), .stimData(sd1),
        .stimCtl(sc1), .stimValid(sv1), .obsData(obs1), .busy(busy1), .done(done1),
        .pass(pass1), .failCount(fc1), .failIndex(fi1), .failObs(fo1)
`ifdef EDP_VEC_SIGNATURE_EN
        , .sig(sig1)
`endif
    );

    edp_vec_player #(.WIDTH(36), .CTL_W(32), .DEPTH(16), .LAT(3)) dut3 (
        .eboxClk(eboxClk), .eboxReset_n(eboxReset_n), .wrEn(wrEn), .wrAddr(wrAddr),
        .wrData(wrData), .wrCtl(wrCtl), .wrExp(wrExp), .wrMask(wrMask), .count(count),
        .start(start3), .abort(abort3), .stopOnFail(stopOnFail), .stimData(sd3),
        .stimCtl(sc3), .stimValid(sv3), .obsData(obs3), .busy(busy3), .done(done3),
        .pass(pass3), .failCount(fc3), .failIndex(fi3), .failObs(fo3)
`ifdef EDP_VEC_SIGNATURE_EN
        , .sig(sig3)
`endif
    );

    logic        sel;
    logic        d_sv, d_done, d_pass;
    logic [4:0]  d_fc;
    logic [3:0]  d_fi;
    logic [35:0] d_fo, d_sd;
    assign d_sv   = sel ? sv3   : sv1;
    assign d_done = sel ? done3 : done1;
    assign d_pass = sel ? pass3 : pass1;
    assign d_fc   = sel ? fc3   : fc1;
    assign d_fi   = sel ? fi3   : fi1;
    assign d_fo   = sel ? fo3   : fo1;
    assign d_sd   = sel ? sd3   : sd1;

    int total = 0;
    int bad   = 0;

    logic [35:0] m_data [16];
    logic [31:0] m_ctl  [16];
    logic [35:0] m_exp  [16];
    logic [35:0] m_mask [16];

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic wr(input int a, input logic [35:0] d, input logic [31:0] c,
                      input logic [35:0] e, input logic [35:0] m);
        wrEn = 1'b1; wrAddr = 4'(a); wrData = d; wrCtl = c; wrExp = e; wrMask = m;
        m_data[a] = d; m_ctl[a] = c; m_exp[a] = e; m_mask[a] = m;
        @(negedge eboxClk);
        wrEn = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int lat, output int svc, output logic [35:0] first_sd);
        bit seen = 0;
        lat = 0; svc = 0; first_sd = '0;
        for (int k = k0; k < k0 + 400; k++) begin
            if (d_sv) begin
                svc++;
                if (!seen) begin first_sd = d_sd; seen = 1; end
            end
            if (d_done) begin lat = k; break; end
            @(negedge eboxClk);
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done want done within 400 cycles");
        end
    endtask

    task automatic run(input bit which, input int cnt, input bit sof,
                       output int lat, output int svc, output logic [35:0] first_sd);
        sel = which; count = 5'(cnt); stopOnFail = sof;
        if (which) start3 = 1'b1; else start1 = 1'b1;
        @(negedge eboxClk);
        start1 = 1'b0; start3 = 1'b0;
        wait_done(1, lat, svc, first_sd);
    endtask

    typedef struct {
        int          cnt;
        bit          sof;
        logic [35:0] mask2;
        int          lat;
        int          svc;
        int          fc;
        int          fi;
        logic [35:0] fo;
        bit          pass;
    } row_t;

    row_t tbl [5];

    initial begin
        int lat, svc;
        logic [35:0] fsd;
        localparam logic [35:0] ONES = 36'hFFFFFFFFF;

        tbl[0] = '{1, 1'b0, ONES,          3, 2, 0, 0, 36'h0,   1'b1};
        tbl[1] = '{4, 1'b0, ONES,          9, 8, 1, 2, 36'h259, 1'b0};
        tbl[2] = '{4, 1'b0, 36'hFFFFFFFFE, 9, 8, 0, 0, 36'h0,   1'b1};
        tbl[3] = '{4, 1'b1, ONES,          7, 6, 1, 2, 36'h259, 1'b0};
        tbl[4] = '{0, 1'b0, ONES,          1, 0, 0, 0, 36'h0,   1'b1};

        eboxReset_n = 1'b0; wrEn = 0; wrAddr = 0; wrData = 0; wrCtl = 0; wrExp = 0; wrMask = 0;
        count = 0; start1 = 0; start3 = 0; abort1 = 0; abort3 = 0; stopOnFail = 0; sel = 0;
        #12;
        chk("reset_outs1", {sd1, sc1, sv1, busy1, done1, pass1, fc1, fi1, fo1}, '0);
        chk("reset_outs3", {sd3, sc3, sv3, busy3, done3, pass3, fc3, fi3, fo3}, '0);
        @(negedge eboxClk);
        eboxReset_n = 1'b1;
        @(negedge eboxClk);

        wr(0, 36'h123456789, 32'h0, 36'h123456789, ONES);
        wr(1, 36'h000000ABC, 32'h0, 36'h000000ABC, ONES);
        wr(2, 36'h000000258, 32'h1, 36'h000000258, ONES);
        wr(3, 36'hF0F0F0F0F, 32'h0, 36'hF0F0F0F0F, ONES);

        for (int r = 0; r < 5; r++) begin
            wr(2, 36'h000000258, 32'h1, 36'h000000258, tbl[r].mask2);
            run(1'b0, tbl[r].cnt, tbl[r].sof, lat, svc, fsd);
            chk($sformatf("row%0d_latency", r), lat, tbl[r].lat);
            chk($sformatf("row%0d_valid_cycles", r), svc, tbl[r].svc);
            chk($sformatf("row%0d_pass", r), d_pass, tbl[r].pass);
            if (tbl[r].cnt != 0) begin
                chk($sformatf("row%0d_failCount", r), d_fc, tbl[r].fc);
                chk($sformatf("row%0d_failIndex", r), d_fi, tbl[r].fi);
                chk($sformatf("row%0d_failObs", r), d_fo, tbl[r].fo);
                chk($sformatf("row%0d_first_stim", r), fsd, 36'h123456789);
            end
            @(negedge eboxClk);
        end

        // LAT=3: four stimulus cycles per vector.
        run(1'b1, 2, 1'b0, lat, svc, fsd);
        chk("lat3_latency", lat, 9);
        chk("lat3_valid_cycles", svc, 8);
        chk("lat3_pass", pass3, 1'b1);
        @(negedge eboxClk);

        // Abort during WAIT of slot 1 (cycle 6 after start).
        count = 5'd2; stopOnFail = 0; start3 = 1'b1;
        @(negedge eboxClk);
        start3 = 1'b0;
        repeat (5) @(negedge eboxClk);
        chk("abort_in_wait_valid", {busy3, done3}, 2'b10);
        abort3 = 1'b1;
        @(negedge eboxClk);
        abort3 = 1'b0;
        chk("abort_done", done3, 1'b1);
        chk("abort_pass", pass3, 1'b0);
        chk("abort_failCount", fc3, 5'd0);
        @(negedge eboxClk);
        chk("abort_idle", {busy3, done3, sv3}, 3'b000);

        // Write and restart while busy must both be ignored.
        sel = 0; count = 5'd4; stopOnFail = 0; start1 = 1'b1;
        @(negedge eboxClk);
        start1 = 1'b0;
        @(negedge eboxClk);
        wrEn = 1'b1; wrAddr = 4'd3; wrData = 36'hF0F0F0F0F; wrCtl = 0; wrExp = 0; wrMask = ONES;
        start1 = 1'b1;
        @(negedge eboxClk);
        wrEn = 1'b0; start1 = 1'b0;
        wait_done(3, lat, svc, fsd);
        chk("busy_wr_latency", lat, 9);
        chk("busy_wr_failCount", fc1, 5'd1);
        @(negedge eboxClk);
        run(1'b0, 4, 1'b0, lat, svc, fsd);
        chk("busy_wr_rerun_failCount", fc1, 5'd1);
        @(negedge eboxClk);

        // Start coincident with a write: slot 0 shows the new contents.
        count = 5'd1; stopOnFail = 0;
        wrEn = 1'b1; wrAddr = 4'd0; wrData = 36'h5; wrCtl = 32'h2; wrExp = 36'h5; wrMask = ONES;
        start1 = 1'b1;
        @(negedge eboxClk);
        wrEn = 1'b0; start1 = 1'b0;
        wait_done(1, lat, svc, fsd);
        chk("coinc_first_stim", fsd, 36'h5);
        chk("coinc_failCount", fc1, 5'd1);
        chk("coinc_failObs", fo1, 36'h7);
        @(negedge eboxClk);

        // Random runs against a slot-by-slot reference.
        for (int it = 0; it < 25; it++) begin
            int cnt, m_fc, m_fi, m_ran;
            bit sof;
            logic [35:0] m_fo, m_sig, o;
            for (int s = 0; s < 16; s++) begin
                logic [35:0] d, e, m;
                logic [31:0] c;
                d = {4'($urandom), 32'($urandom)};
                c = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
                e = ($urandom_range(0, 7) == 0) ? {4'($urandom), 32'($urandom)} : d;
                m = ($urandom_range(0, 1) == 0) ? ONES : {4'($urandom), 32'($urandom)};
                wr(s, d, c, e, m);
            end
            cnt = $urandom_range(1, 16);
            sof = 1'($urandom_range(0, 1));
            m_fc = 0; m_fi = 0; m_fo = '0; m_ran = 0; m_sig = '0;
            for (int i = 0; i < cnt; i++) begin
                m_ran++;
                o = m_data[i] ^ {4'b0, m_ctl[i]};
                m_sig = {m_sig[34:0], m_sig[35] ^ m_sig[33]} ^ o;
                if (((o ^ m_exp[i]) & m_mask[i]) != 0) begin
                    if (m_fc == 0) begin m_fi = i; m_fo = o; end
                    if (m_fc < 31) m_fc++;
                    if (sof) break;
                end
            end
            run(1'b0, cnt, sof, lat, svc, fsd);
            chk($sformatf("rnd%0d_latency", it), lat, 1 + 2*m_ran);
            chk($sformatf("rnd%0d_valid_cycles", it), svc, 2*m_ran);
            chk($sformatf("rnd%0d_failCount", it), fc1, m_fc);
            chk($sformatf("rnd%0d_failIndex", it), fi1, m_fi);
            chk($sformatf("rnd%0d_failObs", it), fo1, m_fo);
            chk($sformatf("rnd%0d_pass", it), pass1, (m_fc == 0));
`ifdef EDP_VEC_SIGNATURE_EN
            chk($sformatf("rnd%0d_sig", it), sig1, m_sig);
`endif
            @(negedge eboxClk);
        end

        // Reset in the middle of a run clears everything without a clock edge.
        sel = 0; count = 5'd16; stopOnFail = 0; start1 = 1'b1;
        @(negedge eboxClk);
        start1 = 1'b0;
        repeat (3) @(negedge eboxClk);
        chk("midrun_busy", busy1, 1'b1);
        #1 eboxReset_n = 1'b0;
        #1;
        chk("midrun_reset_outs", {sd1, sc1, sv1, busy1, done1, pass1, fc1, fi1, fo1}, '0);
        @(negedge eboxClk);
        eboxReset_n = 1'b1;
        repeat (2) @(negedge eboxClk);
        chk("post_reset_idle", {busy1, sv1, done1}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
